// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map constants shared by the GPIO port
package gpio_pkg;

  // Register index within the 8-word window (io_addr[2:0])
  typedef enum logic [2:0] {
    GPIO_IN      = 3'd0,
    GPIO_OUT     = 3'd1,
    GPIO_OE      = 3'd2,
    GPIO_RISE_EN = 3'd3,
    GPIO_FALL_EN = 3'd4,
    GPIO_IRQ_EN  = 3'd5,
    GPIO_STATUS  = 3'd6,
    GPIO_TOGGLE  = 3'd7
  } gpio_reg_e;

  localparam int GPIO_NUM_REGS = 8;
  localparam int GPIO_IDX_W    = $clog2(GPIO_NUM_REGS);
  localparam int GPIO_DATA_W   = 16;

  // True when addr falls inside the register window starting at base
  function automatic logic gpio_addr_hit(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:GPIO_IDX_W] == base[15:GPIO_IDX_W];
  endfunction

endpackage

// File: rtl/gpio_filter.sv
// rtl/gpio_filter.sv - one pin: 2-flop synchroniser, glitch filter, delayed filtered value
module gpio_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic f_o,
  output logic f_d_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser for the asynchronous pad input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      assign f_o = sync2_q;
    end else begin : g_filter
      // Counter only ever holds 0..FILTER_LEN-1; reaching the last value flips the output
      localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
      localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          filt_q;
      logic          filt_d;

      // Count consecutive samples that disagree with the filtered value
      always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
          if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      // Filter state register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          filt_q <= filt_d;
        end
      end

      assign f_o = filt_q;
    end
  endgenerate

  // Previous-cycle filtered value for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= f_o;
    end
  end

  assign f_d_o = prev_q;

endmodule

// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - parametrised GPIO port with edge interrupts on the J1 I/O bus
module gpio_port
  import gpio_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          FILTER_LEN = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      io_addr,
  input  logic [15:0]      io_wdata,
  input  logic             io_wr,
  input  logic             io_rd,
  output logic [15:0]      io_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic             sel;
  logic             wr_en;
  logic             rd_en;
  gpio_reg_e        reg_idx;
  logic [WIDTH-1:0] wdata;

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_prev;
  logic [WIDTH-1:0] edge_set;

  logic [WIDTH-1:0] out_q,     out_d;
  logic [WIDTH-1:0] oe_q,      oe_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_en_q,  irq_en_d;
  logic [WIDTH-1:0] status_q,  status_d;
  logic [WIDTH-1:0] w1c;
  logic             irq_q,     irq_d;
  logic [15:0]      rdata_q,   rdata_d;
  logic [15:0]      rd_mux;

  assign sel     = gpio_addr_hit(io_addr, BASE_ADDR);
  assign wr_en   = io_wr & sel;
  assign rd_en   = io_rd & sel;
  assign reg_idx = gpio_reg_e'(io_addr[GPIO_IDX_W-1:0]);
  assign wdata   = io_wdata[WIDTH-1:0];

  generate
    if (WIDTH < GPIO_DATA_W) begin : g_unused_wdata
      logic unused_wdata_bits;
      assign unused_wdata_bits = ^io_wdata[GPIO_DATA_W-1:WIDTH];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pin
      gpio_filter #(
        .FILTER_LEN(FILTER_LEN)
      ) u_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (gpio_in[gi]),
        .f_o  (filt[gi]),
        .f_d_o(filt_prev[gi])
      );
    end
  endgenerate

  // Enabled edges of the filtered inputs
  assign edge_set = (filt & ~filt_prev & rise_en_q) | (~filt & filt_prev & fall_en_q);

  // Register writes and sticky status; a new edge beats a same-cycle clear
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    w1c       = '0;
    if (wr_en) begin
      case (reg_idx)
        GPIO_OUT:     out_d     = wdata;
        GPIO_OE:      oe_d      = wdata;
        GPIO_RISE_EN: rise_en_d = wdata;
        GPIO_FALL_EN: fall_en_d = wdata;
        GPIO_IRQ_EN:  irq_en_d  = wdata;
        GPIO_STATUS:  w1c       = wdata;
        GPIO_TOGGLE:  out_d     = out_q ^ wdata;
        default:      ;
      endcase
    end
    status_d = (status_q & ~w1c) | edge_set;
    irq_d    = |(status_q & irq_en_q);
  end

  // Read mux over the current register values, so a same-cycle write is not seen
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      GPIO_IN:      rd_mux[WIDTH-1:0] = filt;
      GPIO_OUT:     rd_mux[WIDTH-1:0] = out_q;
      GPIO_OE:      rd_mux[WIDTH-1:0] = oe_q;
      GPIO_RISE_EN: rd_mux[WIDTH-1:0] = rise_en_q;
      GPIO_FALL_EN: rd_mux[WIDTH-1:0] = fall_en_q;
      GPIO_IRQ_EN:  rd_mux[WIDTH-1:0] = irq_en_q;
      GPIO_STATUS:  rd_mux[WIDTH-1:0] = status_q;
      default:      rd_mux = '0;
    endcase
    rdata_d = rd_en ? rd_mux : rdata_q;
  end

  // Control/status registers, interrupt and read data holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_en_q  <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_en_q  <= irq_en_d;
      status_q  <= status_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;
  assign irq      = irq_q;
  assign io_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - scoreboard bench for gpio_port with a window-based reference model
module tb_gpio_port;

  localparam int          W    = 8;
  localparam int          FL   = 4;
  localparam logic [15:0] BASE = 16'h0010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   io_addr;
  logic [15:0]   io_wdata;
  logic          io_wr;
  logic          io_rd;
  logic [15:0]   io_rdata;
  logic [W-1:0]  gpio_in;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  int n_cmp  = 0;
  int n_fail = 0;

  gpio_port #(.WIDTH(W), .FILTER_LEN(FL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_wr(io_wr), .io_rd(io_rd), .io_rdata(io_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register semantics plus "filtered value = value the
  // synchronised pin has held for the last FL samples, otherwise unchanged"
  logic [W-1:0]  m_out, m_oe, m_ren, m_fen, m_ien, m_st, m_f, m_fprev;
  logic          m_irq;
  logic [W-1:0]  ph [0:FL+1];
  logic [15:0]   exp_q [$];
  logic [W-1:0]  m_set, m_w1c, m_all1, m_all0, m_wd;
  logic          m_sel;

  function automatic logic [15:0] model_read(input logic [2:0] r);
    logic [W-1:0] v;
    case (r)
      3'd0: v = m_f;
      3'd1: v = m_out;
      3'd2: v = m_oe;
      3'd3: v = m_ren;
      3'd4: v = m_fen;
      3'd5: v = m_ien;
      3'd6: v = m_st;
      default: v = '0;
    endcase
    return {{(16-W){1'b0}}, v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_oe = '0; m_ren = '0; m_fen = '0; m_ien = '0; m_st = '0;
      m_f = '0; m_fprev = '0; m_irq = 1'b0;
      for (int i = 0; i <= FL + 1; i++) ph[i] = '0;
      exp_q.delete();
    end else begin
      m_sel = (io_addr >> 3) == (BASE >> 3);
      m_wd  = io_wdata[W-1:0];
      if (m_sel && io_rd) exp_q.push_back(model_read(io_addr[2:0]));
      m_set = (m_f & ~m_fprev & m_ren) | (~m_f & m_fprev & m_fen);
      m_irq = |(m_st & m_ien);
      m_w1c = '0;
      if (m_sel && io_wr) begin
        case (io_addr[2:0])
          3'd1: m_out = m_wd;
          3'd2: m_oe  = m_wd;
          3'd3: m_ren = m_wd;
          3'd4: m_fen = m_wd;
          3'd5: m_ien = m_wd;
          3'd6: m_w1c = m_wd;
          3'd7: m_out = m_out ^ m_wd;
          default: ;
        endcase
      end
      m_st = (m_st & ~m_w1c) | m_set;
      for (int i = FL + 1; i > 0; i--) ph[i] = ph[i-1];
      ph[0]  = gpio_in;
      m_all1 = '1;
      m_all0 = '1;
      for (int k = 2; k <= FL + 1; k++) begin
        m_all1 = m_all1 & ph[k];
        m_all0 = m_all0 & ~ph[k];
      end
      m_fprev = m_f;
      m_f     = (m_f | m_all1) & ~m_all0;
    end
  end

  // Monitor: pops read expectations when read data is due, tracks pin outputs every cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("rdata", io_rdata, exp_q.pop_front());
    check("gpio_out", {8'h00, gpio_out}, {8'h00, m_out});
    check("gpio_oe",  {8'h00, gpio_oe},  {8'h00, m_oe});
    check("irq",      {15'h0, irq},      {15'h0, m_irq});
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] d);
    io_addr = BASE | {13'h0, r}; io_wdata = d; io_wr = 1'b1;
    idle(1);
    io_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] r);
    io_addr = BASE | {13'h0, r}; io_rd = 1'b1;
    idle(1);
    io_rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; io_addr = '0; io_wdata = '0; io_wr = 1'b0; io_rd = 1'b0; gpio_in = '0;
    idle(3);
    check("rst_out",   {8'h00, gpio_out}, 16'h0000);
    check("rst_oe",    {8'h00, gpio_oe},  16'h0000);
    check("rst_irq",   {15'h0, irq},      16'h0000);
    check("rst_rdata", io_rdata,          16'h0000);
    rst_n = 1'b1;
    idle(2);

    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h00A5);
    check("out_a5", {8'h00, gpio_out}, 16'h00A5);
    check("oe_ff",  {8'h00, gpio_oe},  16'h00FF);
    rd(3'd1);
    check("rd_out", io_rdata, 16'h00A5);

    wr(3'd7, 16'h000F);
    check("toggle", {8'h00, gpio_out}, 16'h00AA);
    rd(3'd7);
    check("rd_toggle", io_rdata, 16'h0000);

    wr(3'd3, 16'h0004);
    wr(3'd5, 16'h0004);
    gpio_in[2] = 1'b1;
    idle(3);
    gpio_in[2] = 1'b0;
    idle(8);
    rd(3'd0);
    check("glitch_in", io_rdata, 16'h0000);
    rd(3'd6);
    check("glitch_st", io_rdata, 16'h0000);

    gpio_in[2] = 1'b1;
    idle(5);
    rd(3'd0);
    check("in_early", io_rdata, 16'h0000);
    rd(3'd0);
    check("in_edge6", io_rdata, 16'h0004);
    check("irq_p7", {15'h0, irq}, 16'h0000);
    idle(1);
    check("irq_p8", {15'h0, irq}, 16'h0001);
    rd(3'd6);
    check("st_rise", io_rdata, 16'h0004);
    wr(3'd6, 16'h0004);
    check("irq_w1c_1", {15'h0, irq}, 16'h0001);
    idle(1);
    check("irq_w1c_2", {15'h0, irq}, 16'h0000);

    wr(3'd4, 16'h0001);
    gpio_in[0] = 1'b1;
    idle(8);
    gpio_in[0] = 1'b0;
    idle(6);
    wr(3'd6, 16'h0001);
    rd(3'd6);
    check("collision", io_rdata, 16'h0001);

    wr(3'd3, 16'h00FF);
    wr(3'd4, 16'h00FF);
    gpio_in = 8'hFF;
    idle(8);
    gpio_in = 8'h00;
    idle(8);
    rd(3'd6);
    check("st_all", io_rdata, 16'h00FF);
    gpio_in = 8'hFF;
    idle(5);
    rst_n = 1'b0;
    idle(1);
    check("mid_out",   {8'h00, gpio_out}, 16'h0000);
    check("mid_oe",    {8'h00, gpio_oe},  16'h0000);
    check("mid_irq",   {15'h0, irq},      16'h0000);
    check("mid_rdata", io_rdata,          16'h0000);
    idle(1);
    rst_n = 1'b1;
    idle(10);
    rd(3'd6);
    check("post_rst_st", io_rdata, 16'h0000);
    rd(3'd0);
    check("post_rst_in", io_rdata, 16'h00FF);

    for (int i = 0; i < 1500; i++) begin
      io_rd    = ($urandom_range(0, 99) < 30);
      io_wr    = ($urandom_range(0, 99) < 30);
      io_wdata = 16'($urandom);
      if ($urandom_range(0, 99) < 88) io_addr = BASE | 16'($urandom_range(0, 7));
      else io_addr = 16'($urandom);
      if ($urandom_range(0, 99) < 12) gpio_in[$urandom_range(0, W-1)] ^= 1'b1;
      if (i == 700) rst_n = 1'b0;
      if (i == 702) rst_n = 1'b1;
      idle(1);
    end
    io_rd = 1'b0;
    io_wr = 1'b0;
    idle(4);
    check("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised general-purpose I/O port for the J1 I/O bus, the successor to the fixed 8-bit GPIO currently split between the top-level tristate logic and the CSR block. It provides WIDTH pins, each with its own direction. Inputs are synchronised and glitch-filtered. It also provides per-pin rising/falling edge detection, sticky interrupt status with write-1-to-clear, an atomic output toggle register, and a single registered interrupt output. The pad tristate (`oe ? out : z`) stays in the top level; this block drives `gpio_out`/`gpio_oe` and samples `gpio_in`.

## Interface
- WIDTH, 8: number of pins, 1..16.
- FILTER_LEN, 4: consecutive stable samples required before a pin's filtered value changes; 0 = filter bypassed.
- BASE_ADDR, 16'h0010: I/O base address, 8-word aligned.

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- io_addr  in  16  J1 I/O address
- io_wdata  in  16  J1 I/O write data
- io_wr  in  1  single-cycle write strobe
- io_rd  in  1  single-cycle read strobe
- io_rdata  out  16  read data, registered
- gpio_in  in  WIDTH  raw pad inputs, asynchronous
- gpio_out  out  WIDTH  output data to pads
- gpio_oe  out  WIDTH  output enables, 1 = drive
- irq  out  1  level interrupt, registered

## Operation
- Select: `io_addr[15:3] == BASE_ADDR[15:3]`. Register index = `io_addr[2:0]`. Unselected accesses are ignored.
- Registers (bits above WIDTH read 0, writes ignored):
  - 0 IN: filtered input value, read-only
  - 1 OUT: read/write
  - 2 OE: read/write
  - 3 RISE_EN: read/write
  - 4 FALL_EN: read/write
  - 5 IRQ_EN: read/write
  - 6 STATUS: read; write-1-to-clear
  - 7 TOGGLE: write-only, `OUT <= OUT ^ wdata`; reads 0
- Input path per pin:
  - 2-flop synchroniser, then filter.
  - Filter: counter resets whenever the synchronised value equals the filtered value. Otherwise it increments; when it reaches FILTER_LEN, the filtered value takes the synchronised value and the counter clears.
- Edge detection on filtered value vs its previous cycle:
  - `rise = f & ~f_d & RISE_EN`
  - `fall = ~f & f_d & FALL_EN`
  - Either sets the STATUS bit.
- STATUS set and W1C clear on the same bit in the same cycle: set wins.
- `irq <= |(STATUS & IRQ_EN)`.
- Reads:
  - `io_rdata` loads the selected register on the cycle `io_rd` is high and holds until the next selected read.
  - A read of STATUS has no side effect.
- `io_rd` and `io_wr` in the same cycle: the write takes effect; the read returns the pre-write value.
- Reset (rst_n low, any time including mid-filter): OUT, OE, RISE_EN, FALL_EN, IRQ_EN, STATUS, synchronisers, filtered values, `f_d` and counters all go to 0. Outputs: `gpio_out = 0`, `gpio_oe = 0`, `irq = 0`, `io_rdata = 0`.
- After reset, a pin held high produces a filtered rise. This rise sets STATUS only if RISE_EN is already set.

## Timing
- Register write visible on `gpio_out`/`gpio_oe`: 1 cycle after the `io_wr` edge.
- Read data valid: the cycle after `io_rd`.
- Pin change to filtered change: 2 (sync) + FILTER_LEN cycles, with FILTER_LEN = 0 giving 2 cycles.
- Filtered change to STATUS set: +1 cycle. STATUS to `irq`: +1 cycle.
- A glitch shorter than FILTER_LEN synchronised cycles never reaches IN or STATUS.
- Enabling IRQ_EN with STATUS already set raises `irq` 2 cycles after the write.
- Clearing the last pending bit drops `irq` 2 cycles after the write.

## Structure
- `gpio_pkg`: register index constants (GPIO_IN .. GPIO_TOGGLE) and the register-count constant.
- Sub-module `gpio_filter`: one pin's synchroniser, counter, filtered value and `f_d`, parametrised by FILTER_LEN. Instantiated WIDTH times in a generate loop.
- The top level of this block contains the address decode, registers, edge/STATUS logic and the read mux.

## Test plan
- Reset: all outputs are 0. Write OE = 0xFF and OUT = 0xA5 -> `gpio_out = 0xA5` and `gpio_oe = 0xFF` one cycle later. Read reg 1 -> 0x00A5.
- TOGGLE: with OUT = 0xA5, write 0x0F to reg 7 -> OUT = 0xAA. Read reg 7 -> 0.
- Filter (FILTER_LEN = 4): a 3-cycle high pulse on `gpio_in[2]` -> IN stays 0 and STATUS stays 0. A sustained high -> IN[2] = 1 exactly 6 cycles after the pin edge.
- Edge/IRQ: RISE_EN = 0x04, IRQ_EN = 0x04, `gpio_in[2]` rises -> STATUS = 0x04 at +7 cycles and `irq` = 1 at +8. Write 0x04 to reg 6 -> `irq` = 0 two cycles later.
- Set-vs-clear collision: a falling edge on pin 0 (FALL_EN[0] = 1) in the same cycle as a W1C of bit 0 -> STATUS[0] remains 1.
- Reset mid-operation: assert rst_n while a filter counter is at 3 and STATUS = 0xFF -> all state is 0 on the next observation. After release, a held-high input with RISE_EN = 0 leaves STATUS = 0.
